// File: rtl/dtcm_arbiter.sv
// dtcm_arbiter: shares the single-port DTCM RAM between two command masters.
//
// Grants at most one command per cycle (round-robin on ties) and drives the RAM
// combinationally in the grant cycle. The synchronous-read result is returned one
// cycle later. A holding register captures the response if the owner stalls its
// response channel, so the RAM output is only sampled in the first response cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   m{0,1}_cmd_valid/ready        command handshake per master
//   m{0,1}_cmd_read/addr/wmask/wdata
//                                 command payload (addr is a byte address)
//   m{0,1}_rsp_valid/ready        response handshake per master
//   m{0,1}_rsp_rdata              read data (0 for write responses)
//   ram_cs/we/addr/wem/din        RAM command, valid in the grant cycle
//   ram_dout                      RAM read data, valid the cycle after a read
module dtcm_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned MW = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_cmd_valid,
  output logic          m0_cmd_ready,
  input  logic          m0_cmd_read,
  input  logic [AW-1:0] m0_cmd_addr,
  input  logic [MW-1:0] m0_cmd_wmask,
  input  logic [DW-1:0] m0_cmd_wdata,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_rdata,

  input  logic          m1_cmd_valid,
  output logic          m1_cmd_ready,
  input  logic          m1_cmd_read,
  input  logic [AW-1:0] m1_cmd_addr,
  input  logic [MW-1:0] m1_cmd_wmask,
  input  logic [DW-1:0] m1_cmd_wdata,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_rdata,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-3:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  // Outstanding-response state
  logic          pend_q, pend_d;
  logic          owner_q, owner_d;
  logic          is_rd_q, is_rd_d;
  logic          hold_vld_q, hold_vld_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          last_gnt_q, last_gnt_d;

  logic          owner_rsp_ready;
  logic          retire;
  logic          slot_free;
  logic          accept;
  logic          winner;
  logic [DW-1:0] rsp_data;

  logic          gnt_read;
  logic [AW-3:0] gnt_word;
  logic [MW-1:0] gnt_wmask;
  logic [DW-1:0] gnt_wdata;

  // Byte-offset bits never reach the word-addressed RAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_cmd_addr[1:0], m1_cmd_addr[1:0]};

  // Slot availability: a retiring response frees the slot in the same cycle.
  always_comb begin
    owner_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;
    retire          = pend_q & owner_rsp_ready;
    slot_free       = ~pend_q | retire;
  end

  // Arbitration: single requester wins outright; on a tie the port that was not
  // granted last time wins.
  always_comb begin
    winner = 1'b0;
    if (m0_cmd_valid && m1_cmd_valid) begin
      winner = ~last_gnt_q;
    end else if (m1_cmd_valid) begin
      winner = 1'b1;
    end
    accept = slot_free & (m0_cmd_valid | m1_cmd_valid);
  end

  assign m0_cmd_ready = accept & ~winner;
  assign m1_cmd_ready = accept & winner;

  // Granted command payload
  always_comb begin
    gnt_read  = winner ? m1_cmd_read              : m0_cmd_read;
    gnt_word  = winner ? m1_cmd_addr[AW-1:2]      : m0_cmd_addr[AW-1:2];
    gnt_wmask = winner ? m1_cmd_wmask             : m0_cmd_wmask;
    gnt_wdata = winner ? m1_cmd_wdata             : m0_cmd_wdata;
  end

  // RAM drive; payload forced to zero when nothing is accepted.
  always_comb begin
    ram_cs   = accept;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    if (accept) begin
      ram_we   = ~gnt_read;
      ram_addr = gnt_word;
      ram_wem  = gnt_wmask;
      ram_din  = gnt_wdata;
    end
  end

  // Response data: captured copy wins once the first response cycle has passed.
  always_comb begin
    if (hold_vld_q) begin
      rsp_data = hold_data_q;
    end else if (is_rd_q) begin
      rsp_data = ram_dout;
    end else begin
      rsp_data = '0;
    end
  end

  always_comb begin
    m0_rsp_valid = pend_q & ~owner_q;
    m1_rsp_valid = pend_q & owner_q;
    m0_rsp_rdata = m0_rsp_valid ? rsp_data : '0;
    m1_rsp_rdata = m1_rsp_valid ? rsp_data : '0;
  end

  // Next state
  always_comb begin
    pend_d      = pend_q;
    owner_d     = owner_q;
    is_rd_d     = is_rd_q;
    last_gnt_d  = last_gnt_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;

    if (accept) begin
      pend_d     = 1'b1;
      owner_d    = winner;
      is_rd_d    = gnt_read;
      last_gnt_d = winner;
    end else if (retire) begin
      pend_d = 1'b0;
    end

    if (retire) begin
      hold_vld_d = 1'b0;
    end else if (pend_q && !hold_vld_q) begin
      // Owner stalled in the first response cycle: freeze the data now, the RAM
      // output may change from the next cycle on.
      hold_vld_d  = 1'b1;
      hold_data_d = rsp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      owner_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      last_gnt_q  <= 1'b1;
    end else begin
      pend_q      <= pend_d;
      owner_q     <= owner_d;
      is_rd_q     <= is_rd_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Testbench for dtcm_arbiter: directed scenarios followed by randomized traffic.
// A reference model predicts handshakes and pushes expected read data into
// per-port queues; a separate monitor pops and compares on each response.
module tb_dtcm_arbiter;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 4;
  localparam int unsigned Words = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
  logic [AW-1:0] m0_cmd_addr;
  logic [MW-1:0] m0_cmd_wmask;
  logic [DW-1:0] m0_cmd_wdata;
  logic          m0_rsp_valid, m0_rsp_ready;
  logic [DW-1:0] m0_rsp_rdata;
  logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
  logic [AW-1:0] m1_cmd_addr;
  logic [MW-1:0] m1_cmd_wmask;
  logic [DW-1:0] m1_cmd_wdata;
  logic          m1_rsp_valid, m1_rsp_ready;
  logic [DW-1:0] m1_rsp_rdata;
  logic          ram_cs, ram_we;
  logic [AW-3:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;

  dtcm_arbiter #(.AW(AW), .DW(DW), .MW(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_cmd_valid (m0_cmd_valid),
    .m0_cmd_ready (m0_cmd_ready),
    .m0_cmd_read  (m0_cmd_read),
    .m0_cmd_addr  (m0_cmd_addr),
    .m0_cmd_wmask (m0_cmd_wmask),
    .m0_cmd_wdata (m0_cmd_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_ready (m0_rsp_ready),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m1_cmd_valid (m1_cmd_valid),
    .m1_cmd_ready (m1_cmd_ready),
    .m1_cmd_read  (m1_cmd_read),
    .m1_cmd_addr  (m1_cmd_addr),
    .m1_cmd_wmask (m1_cmd_wmask),
    .m1_cmd_wdata (m1_cmd_wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_ready (m1_rsp_ready),
    .m1_rsp_rdata (m1_rsp_rdata),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wem      (ram_wem),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] ref_mem [Words];
  logic [DW-1:0] ram_mem [Words];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int p, input logic v, input logic rd, input logic [AW-1:0] a,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
    if (p == 0) begin
      m0_cmd_valid = v; m0_cmd_read = rd; m0_cmd_addr = a; m0_cmd_wmask = m; m0_cmd_wdata = d;
    end else begin
      m1_cmd_valid = v; m1_cmd_read = rd; m1_cmd_addr = a; m1_cmd_wmask = m; m1_cmd_wdata = d;
    end
  endtask

  // RAM environment: synchronous read; output is garbage whenever no read occurred.
  initial begin
    for (int i = 0; i < int'(Words); i++) ram_mem[i] = '0;
    ram_mem[4] = 32'hDEADBEEF;
    ram_mem[8] = 32'hAAAAAAAA;
    ram_dout <= '0;
    forever begin
      @(posedge clk);
      if (ram_cs && !ram_we) ram_dout <= ram_mem[ram_addr];
      else ram_dout <= $urandom;
      if (ram_cs && ram_we) begin
        for (int b = 0; b < int'(MW); b++)
          if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
      end
    end
  end

  // Reference model: one outstanding response, round-robin on ties.
  initial begin
    bit            m_pend, m_owner, m_last;
    logic [1:0]    v, rr;
    logic          retire, free, acc, win, rd;
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [DW-1:0] d, e;
    for (int i = 0; i < int'(Words); i++) ref_mem[i] = '0;
    ref_mem[4] = 32'hDEADBEEF;
    ref_mem[8] = 32'hAAAAAAAA;
    m_pend = 1'b0; m_owner = 1'b0; m_last = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("rst_m0_cmd_ready", m0_cmd_ready, 1'b0);
        chk1("rst_m1_cmd_ready", m1_cmd_ready, 1'b0);
        chk1("rst_m0_rsp_valid", m0_rsp_valid, 1'b0);
        chk1("rst_m1_rsp_valid", m1_rsp_valid, 1'b0);
        chk1("rst_ram_cs", ram_cs, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk32("rst_m0_rdata", m0_rsp_rdata, 32'h0);
        chk32("rst_m1_rdata", m1_rsp_rdata, 32'h0);
        m_pend = 1'b0; m_last = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
      end else begin
        v  = {m1_cmd_valid, m0_cmd_valid};
        rr = {m1_rsp_ready, m0_rsp_ready};
        chk1("m0_rsp_valid", m0_rsp_valid, m_pend && !m_owner);
        chk1("m1_rsp_valid", m1_rsp_valid, m_pend && m_owner);
        retire = m_pend && rr[m_owner];
        free   = !m_pend || retire;
        acc    = free && (v != 2'b00);
        win    = (v == 2'b11) ? !m_last : v[1];
        chk1("m0_cmd_ready", m0_cmd_ready, acc && !win);
        chk1("m1_cmd_ready", m1_cmd_ready, acc && win);
        chk1("ram_cs", ram_cs, acc);
        if (acc) begin
          if (win) begin
            rd = m1_cmd_read; a = m1_cmd_addr; m = m1_cmd_wmask; d = m1_cmd_wdata;
          end else begin
            rd = m0_cmd_read; a = m0_cmd_addr; m = m0_cmd_wmask; d = m0_cmd_wdata;
          end
          chk1("ram_we", ram_we, !rd);
          chk32("ram_addr", 32'(ram_addr), 32'(a[AW-1:2]));
          chk32("ram_wem", 32'(ram_wem), 32'(m));
          chk32("ram_din", ram_din, d);
          if (rd) begin
            e = ref_mem[a[AW-1:2]];
          end else begin
            e = '0;
            for (int b = 0; b < int'(MW); b++)
              if (m[b]) ref_mem[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
          end
          if (win) exp_q1.push_back(e);
          else exp_q0.push_back(e);
          m_pend = 1'b1; m_owner = win; m_last = win;
        end else begin
          chk1("idle_ram_we", ram_we, 1'b0);
          chk32("idle_ram_addr", 32'(ram_addr), 32'h0);
          chk32("idle_ram_din", ram_din, 32'h0);
          if (retire) m_pend = 1'b0;
        end
      end
    end
  end

  // Response monitor: pops expected data on each completed response handshake.
  initial begin
    logic [1:0]    rv, rr;
    logic [DW-1:0] rd   [2];
    logic [DW-1:0] held [2];
    bit            stalled [2];
    logic [DW-1:0] e;
    stalled[0] = 1'b0; stalled[1] = 1'b0;
    forever begin
      @(negedge clk);
      rv = {m1_rsp_valid, m0_rsp_valid};
      rr = {m1_rsp_ready, m0_rsp_ready};
      rd[0] = m0_rsp_rdata;
      rd[1] = m1_rsp_rdata;
      if (rst) begin
        stalled[0] = 1'b0; stalled[1] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (rv[1-p]) chk32("nonowner_rdata_zero", rd[p], 32'h0);
          if (rv[p]) begin
            if (stalled[p]) chk32("stall_hold_rdata", rd[p], held[p]);
            if (rr[p]) begin
              if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                n_chk++;
                n_err++;
                $display("FAIL rsp_unexpected port %0d: got 0x%08h with none expected", p, rd[p]);
              end else begin
                if (p == 0) e = exp_q0.pop_front();
                else e = exp_q1.pop_front();
                chk32("rsp_rdata", rd[p], e);
              end
              stalled[p] = 1'b0;
            end else begin
              stalled[p] = 1'b1;
              held[p]    = rd[p];
            end
          end else begin
            stalled[p] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    bit fired0, fired1;
    rst = 1'b1;
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    step();
    rst = 1'b0;

    // Continuous reads from both ports alternate, m0 first after reset.
    set_cmd(0, 1'b1, 1'b1, 16'h0040, 4'h0, 32'h0);
    set_cmd(1, 1'b1, 1'b1, 16'h0044, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("alt_m0_ready", m0_cmd_ready, (i % 2) == 0);
      chk1("alt_m1_ready", m1_cmd_ready, (i % 2) == 1);
      step();
    end
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);

    // Single m0 read of preloaded word 4.
    set_cmd(0, 1'b1, 1'b1, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    chk1("rd_cs", ram_cs, 1'b1);
    chk32("rd_addr", 32'(ram_addr), 32'd4);
    step();
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk1("rd_rsp_valid", m0_rsp_valid, 1'b1);
    chk32("rd_rdata", m0_rsp_rdata, 32'hDEADBEEF);
    step();

    // Masked m1 write then m0 read of the same word in the next cycle.
    set_cmd(1, 1'b1, 1'b0, 16'h0020, 4'b0011, 32'h12345678);
    @(negedge clk);
    chk1("wr_m1_ready", m1_cmd_ready, 1'b1);
    chk1("wr_we", ram_we, 1'b1);
    step();
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    set_cmd(0, 1'b1, 1'b1, 16'h0020, 4'h0, 32'h0);
    @(negedge clk);
    chk1("wr_rsp_valid", m1_rsp_valid, 1'b1);
    chk32("wr_rsp_rdata", m1_rsp_rdata, 32'h0);
    chk1("raw_m0_ready", m0_cmd_ready, 1'b1);
    step();
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk32("raw_rdata", m0_rsp_rdata, 32'hAAAA5678);
    step();

    // m0 stalls its response for three cycles while both ports request.
    m0_rsp_ready = 1'b0;
    set_cmd(0, 1'b1, 1'b1, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    chk1("stall_acc", m0_cmd_ready, 1'b1);
    step();
    set_cmd(0, 1'b1, 1'b1, 16'h0024, 4'h0, 32'h0);
    set_cmd(1, 1'b1, 1'b1, 16'h0020, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("stall_valid", m0_rsp_valid, 1'b1);
      chk32("stall_rdata", m0_rsp_rdata, 32'hDEADBEEF);
      chk1("stall_m0_ready", m0_cmd_ready, 1'b0);
      chk1("stall_m1_ready", m1_cmd_ready, 1'b0);
      step();
    end
    m0_rsp_ready = 1'b1;
    @(negedge clk);
    chk1("unstall_m1_ready", m1_cmd_ready, 1'b1);
    chk1("unstall_m0_ready", m0_cmd_ready, 1'b0);
    chk32("unstall_rdata", m0_rsp_rdata, 32'hDEADBEEF);
    step();
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk32("unstall_m1_rdata", m1_rsp_rdata, 32'hAAAA5678);
    chk1("unstall_m0_acc", m0_cmd_ready, 1'b1);
    step();
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    step();

    // Reset asserted in the response cycle of a pending read.
    set_cmd(0, 1'b1, 1'b1, 16'h0010, 4'h0, 32'h0);
    @(negedge clk);
    chk1("rst_pre_acc", m0_cmd_ready, 1'b1);
    step();
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    m0_rsp_ready = 1'b0;
    #1;
    chk1("rst_pre_valid", m0_rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rst_async_valid", m0_rsp_valid, 1'b0);
    @(negedge clk);
    step();
    rst = 1'b0;
    m0_rsp_ready = 1'b1;
    set_cmd(0, 1'b1, 1'b1, 16'h0010, 4'h0, 32'h0);
    set_cmd(1, 1'b1, 1'b1, 16'h0020, 4'h0, 32'h0);
    @(negedge clk);
    chk1("rst_tie_m0", m0_cmd_ready, 1'b1);
    chk1("rst_tie_m1", m1_cmd_ready, 1'b0);
    step();
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk1("rst_then_m1", m1_cmd_ready, 1'b1);
    step();
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    step();

    // Randomized traffic; commands held stable until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fired0 = m0_cmd_valid && m0_cmd_ready;
      fired1 = m1_cmd_valid && m1_cmd_ready;
      step();
      if (!m0_cmd_valid || fired0)
        set_cmd(0, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                AW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)), MW'($urandom), $urandom);
      if (!m1_cmd_valid || fired1)
        set_cmd(1, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                AW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)), MW'($urandom), $urandom);
      m0_rsp_ready = $urandom_range(0, 3) != 0;
      m1_rsp_ready = $urandom_range(0, 3) != 0;
    end

    // Drain and confirm every expected response was delivered.
    @(negedge clk);
    fired0 = m0_cmd_valid && m0_cmd_ready;
    fired1 = m1_cmd_valid && m1_cmd_ready;
    step();
    if (!fired0) m0_cmd_valid = m0_cmd_valid;
    set_cmd(0, m0_cmd_valid && !fired0, m0_cmd_read, m0_cmd_addr, m0_cmd_wmask, m0_cmd_wdata);
    set_cmd(1, m1_cmd_valid && !fired1, m1_cmd_read, m1_cmd_addr, m1_cmd_wmask, m1_cmd_wdata);
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;
    repeat (4) step();
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) step();
    @(negedge clk);
    chk32("drain_q0", 32'(exp_q0.size()), 32'd0);
    chk32("drain_q1", 32'(exp_q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dtcm_arbiter.md
# dtcm_arbiter

Two-requester arbiter and response sequencer in front of the single-port DTCM RAM. It shares the RAM between the LSU (port m0) and a second master such as debug or DMA (port m1). It grants at most one command per cycle with round-robin fairness, drives the RAM in the grant cycle, and returns the synchronous-read result one cycle later. A response holding register lets either requester stall its response channel without losing data.

## Interface
- `AW`, 16: byte-address width of command ports; RAM word address is `AW-2` bits.
- `DW`, 32: data width.
- `MW`, 4: write byte-mask width (`DW/8`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `m0_cmd_valid`, `m1_cmd_valid` input 1: command request.
- `m0_cmd_ready`, `m1_cmd_ready` output 1: command accepted this cycle when valid&ready.
- `m0_cmd_read`, `m1_cmd_read` input 1: 1 = read, 0 = write.
- `m0_cmd_addr`, `m1_cmd_addr` input AW: byte address; bits [1:0] ignored.
- `m0_cmd_wmask`, `m1_cmd_wmask` input MW: byte enables for writes.
- `m0_cmd_wdata`, `m1_cmd_wdata` input DW: write data.
- `m0_rsp_valid`, `m1_rsp_valid` output 1: response available.
- `m0_rsp_ready`, `m1_rsp_ready` input 1: requester consumes response.
- `m0_rsp_rdata`, `m1_rsp_rdata` output DW: read data; 0 for write responses.
- `ram_cs` output 1: RAM access this cycle.
- `ram_we` output 1: write enable, qualified by `ram_cs`.
- `ram_addr` output AW-2: `cmd_addr[AW-1:2]` of the granted port.
- `ram_wem` output MW: granted port's wmask.
- `ram_din` output DW: granted port's wdata.
- `ram_dout` input DW: RAM read data, valid the cycle after a read access.

## Operation
- Single outstanding response. State `pend`, `owner` (0/1), `is_rd`, `hold_vld`, `hold_data`, `last_gnt`.
- The slot is free when `pend`=0, or when the owner's `rsp_valid & rsp_ready` is true this cycle (same-cycle retire-and-issue).
- Arbitration happens only when the slot is free:
  - only one valid: that port wins.
  - both valid: the port != `last_gnt` wins.
  - `last_gnt` resets to 1, so m0 wins the first tie.
- Only the winner sees `cmd_ready`=1. The loser's `cmd_ready`=0. Commands must hold stable while valid&!ready.
- On accept:
  - `ram_cs`=1, `ram_we`=!read, and addr/wem/din come from the winner, all combinational in the same cycle.
  - Set `pend`=1, `owner`=winner, `is_rd`=read, `last_gnt`=winner.
- Response:
  - `rsp_valid[owner]`=`pend`. The other port's `rsp_valid`=0.
  - `rsp_rdata`: `hold_data` if `hold_vld`; else `ram_dout` if `is_rd`; else 0.
  - The non-owner's rdata is 0.
- Stall capture: in the first response cycle (`pend`&!`hold_vld`), if `rsp_ready`=0, load `hold_data` with the rdata value and set `hold_vld`=1. RAM output is not relied on afterwards.
- Retire: owner `rsp_valid & rsp_ready` clears `hold_vld`. `pend` clears unless a new command is accepted in the same cycle.
- `ram_cs`=0 in cycles with no accept. `ram_we`, `ram_addr`, `ram_wem`, `ram_din` are don't-care then and are driven 0.

## Timing
- Reset values: all `cmd_ready`, `rsp_valid`, `ram_cs`, `ram_we` = 0. All data outputs 0. `pend`=`hold_vld`=0, `last_gnt`=1.
- `cmd_ready` is combinational from `cmd_valid`, `pend` and `rsp_ready`. It is 1 for an idle winner in the same cycle.
- Latency: command accepted in cycle N gives `rsp_valid` in cycle N+1, for both reads and writes.
- Throughput: 1 command/cycle when the owner holds `rsp_ready`=1. Back-to-back commands alternate ports under contention.
- A write accepted in cycle N followed by a read of the same word in cycle N+1 returns the new data. The RAM is write-first across cycles.
- Reset asserted mid-transaction drops `pend` and `rsp_valid` immediately (asynchronous). The in-flight response is lost, and a write already strobed stays committed.

## Test plan
- Single m0 read of addr 0x0010 after preloading word 4 = 0xDEADBEEF: `ram_cs`=1 and `ram_addr`=4 in cycle N; `m0_rsp_valid`=1 with rdata 0xDEADBEEF in N+1.
- Both ports issue continuous reads, rsp_ready=1: grants go m0, m1, m0, m1. `last_gnt` toggles and neither port waits more than 1 cycle.
- m1 write 0x12345678 with wmask 0b0011 to addr 0x20, then m0 reads 0x20 with old word 0xAAAAAAAA: m1 rdata=0, m0 rdata=0xAAAA5678.
- m0 read, then hold `m0_rsp_ready`=0 for 3 cycles while `ram_dout` changes: rdata stays at the captured value, `cmd_ready`=0 for both ports, and m1 is accepted in the cycle `m0_rsp_ready` rises.
- Assert `rst` in the response cycle of a pending read: `rsp_valid` and `pend` go to 0 immediately. After release, the first tie goes to m0.
